// File: rtl/mem_copy_dma.sv
// -----------------------------------------------------------------------------
// mem_copy_dma
//
// Block-copy / block-fill engine that masters a single-port word RAM with a
// one-cycle registered read. One start pulse launches either a copy of len
// words from src to dst, or a fill of len words at dst with a constant. Words
// are moved in ascending order. A copy takes three cycles per word: read
// address, wait, then write. A fill writes one word per cycle.
//
// Ports
//   clk_i            clock, all state updates on the rising edge
//   rst_ni           asynchronous active-low reset
//   start_i          launch request, only looked at while idle
//   mode_i           0 = copy, 1 = fill
//   src_addr_i       first source word (copy only)
//   dst_addr_i       first destination word
//   len_i            word count, 0 is legal (completes with no RAM traffic)
//   fill_data_i      fill constant (fill only)
//   busy_o           high while the engine owns the RAM bus
//   done_o           one-cycle completion pulse
//   wr_en_o          RAM write enable
//   addr_to_ram_o    RAM address
//   data_to_ram_o    RAM write data
//   data_from_ram_i  RAM read data, valid the cycle after the address
//
// Every output is a flop. The output process therefore works from the
// *next* state, so each value is already on the pins during the cycle that
// state is active.
// -----------------------------------------------------------------------------
module mem_copy_dma #(
   parameter int SIZE = 14
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            start_i,
   input  logic            mode_i,
   input  logic [SIZE-1:0] src_addr_i,
   input  logic [SIZE-1:0] dst_addr_i,
   input  logic [SIZE-1:0] len_i,
   input  logic [31:0]     fill_data_i,
   output logic            busy_o,
   output logic            done_o,
   output logic            wr_en_o,
   output logic [SIZE-1:0] addr_to_ram_o,
   output logic [31:0]     data_to_ram_o,
   input  logic [31:0]     data_from_ram_i
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD   = 3'd1,
      S_WT   = 3'd2,
      S_WR   = 3'd3,
      S_FILL = 3'd4,
      S_FIN  = 3'd5
   } state_e;

   // FSM state and the transfer context latched at start
   state_e          state_q, state_d;
   logic [SIZE-1:0] idx_q,   idx_d;
   logic [SIZE-1:0] src_q,   src_d;
   logic [SIZE-1:0] dst_q,   dst_d;
   logic [SIZE-1:0] len_q,   len_d;
   logic [31:0]     fill_q,  fill_d;

   // Registered outputs
   logic            busy_q,  busy_d;
   logic            done_q,  done_d;
   logic            wr_en_q, wr_en_d;
   logic [SIZE-1:0] addr_q,  addr_d;
   logic [31:0]     data_q,  data_d;

   // Index of the word after the one being written. Comparing it to len
   // decides whether the write in progress is the last one. len is never
   // 2**SIZE, so this sum cannot wrap before it matches.
   logic [SIZE-1:0] idx_inc;
   assign idx_inc = idx_q + {{(SIZE-1){1'b0}}, 1'b1};

   // -------------------------------------------------------------------------
   // State register (plus transfer context and output flops)
   // -------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         src_q   <= '0;
         dst_q   <= '0;
         len_q   <= '0;
         fill_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         wr_en_q <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         len_q   <= len_d;
         fill_q  <= fill_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         wr_en_q <= wr_en_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      src_d   = src_q;
      dst_d   = dst_q;
      len_d   = len_q;
      fill_d  = fill_q;

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               src_d  = src_addr_i;
               dst_d  = dst_addr_i;
               len_d  = len_i;
               fill_d = fill_data_i;
               idx_d  = '0;
               // The mode is not kept in a register. The branch taken
               // here (RD loop or FILL loop) already records it.
               if (len_i == '0) begin
                  state_d = S_FIN;
               end else if (!mode_i) begin
                  state_d = S_RD;
               end else begin
                  state_d = S_FILL;
               end
            end
         end

         S_RD: begin
            state_d = S_WT;
         end

         S_WT: begin
            state_d = S_WR;
         end

         S_WR: begin
            idx_d   = idx_inc;
            state_d = (idx_inc == len_q) ? S_FIN : S_RD;
         end

         S_FILL: begin
            idx_d   = idx_inc;
            state_d = (idx_inc == len_q) ? S_FIN : S_FILL;
         end

         S_FIN: begin
            // Any start seen in this cycle is dropped, so starts never queue.
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Output logic: the values for the state being entered. They are
   // registered at the same edge the state changes.
   // -------------------------------------------------------------------------
   always_comb begin
      busy_d  = 1'b0;
      done_d  = 1'b0;
      wr_en_d = 1'b0;
      addr_d  = '0;
      data_d  = data_q;

      case (state_d)
         S_RD: begin
            busy_d = 1'b1;
            addr_d = src_d + idx_d;
         end

         S_WT: begin
            // No new address this cycle. The RAM is returning the read word.
            busy_d = 1'b1;
            addr_d = addr_q;
         end

         S_WR: begin
            // WR is only ever entered from WT, at the edge that closes WT.
            // data_from_ram_i holds mem[src+i] at that edge. The write-data
            // register doubles as the captured-word register, so the value
            // is written out without any extra storage.
            busy_d  = 1'b1;
            wr_en_d = 1'b1;
            addr_d  = dst_d + idx_d;
            data_d  = data_from_ram_i;
         end

         S_FILL: begin
            busy_d  = 1'b1;
            wr_en_d = 1'b1;
            addr_d  = dst_d + idx_d;
            data_d  = fill_d;
         end

         S_FIN: begin
            done_d = 1'b1;
         end

         default: begin
            // Idle: bus released, address parked at zero
         end
      endcase
   end

   assign busy_o        = busy_q;
   assign done_o        = done_q;
   assign wr_en_o       = wr_en_q;
   assign addr_to_ram_o = addr_q;
   assign data_to_ram_o = data_q;

endmodule

// File: tb/tb_mem_copy_dma.sv
// -----------------------------------------------------------------------------
// tb_mem_copy_dma
//
// Drives mem_copy_dma against a behavioural single-port RAM with a
// registered read. For each transfer the stimulus computes the expected
// write stream (address, data, cycle) and the done cycle from plain
// sequential copy/fill arithmetic on a shadow memory, and pushes them into
// queues. A separate monitor pops and compares whenever the DUT writes or
// signals done. After each transfer the whole RAM image is compared with
// the shadow memory.
// -----------------------------------------------------------------------------
module tb_mem_copy_dma;

   localparam int SIZE  = 14;
   localparam int DEPTH = 1 << SIZE;

   logic            clk   = 1'b0;
   logic            rst_n = 1'b0;
   logic            start = 1'b0;
   logic            mode  = 1'b0;
   logic [SIZE-1:0] src   = '0;
   logic [SIZE-1:0] dst   = '0;
   logic [SIZE-1:0] len   = '0;
   logic [31:0]     fill  = '0;
   logic            busy;
   logic            done;
   logic            wr_en;
   logic [SIZE-1:0] addr;
   logic [31:0]     wdata;
   logic [31:0]     rdata;

   always #5 clk = ~clk;

   mem_copy_dma #(.SIZE(SIZE)) dut (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .start_i         (start),
      .mode_i          (mode),
      .src_addr_i      (src),
      .dst_addr_i      (dst),
      .len_i           (len),
      .fill_data_i     (fill),
      .busy_o          (busy),
      .done_o          (done),
      .wr_en_o         (wr_en),
      .addr_to_ram_o   (addr),
      .data_to_ram_o   (wdata),
      .data_from_ram_i (rdata)
   );

   // RAM model: one-cycle registered read, preload port for initial contents
   logic [31:0] mem      [DEPTH];
   logic [31:0] seed_mem [DEPTH];
   logic [31:0] ref_mem  [DEPTH];
   logic        preload = 1'b0;

   always @(posedge clk) begin
      if (preload) begin
         for (int j = 0; j < DEPTH; j++) mem[j] <= seed_mem[j];
      end else if (wr_en) begin
         mem[addr] <= wdata;
      end
      rdata <= mem[addr];
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard
   typedef struct {
      logic [SIZE-1:0] addr;
      logic [31:0]     data;
      int              cyc;
   } wexp_t;

   wexp_t wr_q[$];
   int    done_q[$];
   int    n_cmp   = 0;
   int    n_bad   = 0;
   int    wr_seen = 0;
   int    dn_seen = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: compare every write and every done against the queues
   always @(negedge clk) begin
      if (wr_en) begin
         wr_seen++;
         if (wr_q.size() == 0) begin
            chk("unexpected_write_addr", 32'(addr), 32'hffff_ffff);
         end else begin
            wexp_t e;
            e = wr_q.pop_front();
            chk("wr_addr",  32'(addr), 32'(e.addr));
            chk("wr_data",  wdata,     e.data);
            chk("wr_cycle", cyc,       e.cyc);
            chk("wr_busy",  32'(busy), 32'd1);
         end
      end
      if (done) begin
         dn_seen++;
         if (done_q.size() == 0) begin
            chk("unexpected_done", 32'(done), 32'd0);
         end else begin
            int dc;
            dc = done_q.pop_front();
            chk("done_cycle", cyc,        dc);
            chk("done_busy",  32'(busy),  32'd0);
            chk("done_wren",  32'(wr_en), 32'd0);
         end
      end
   end

   task automatic chk_mem(input string tag);
      int bad;
      bad = 0;
      for (int j = 0; j < DEPTH; j++) begin
         if (mem[j] !== ref_mem[j]) bad++;
      end
      chk({tag, "_mem_image_diffs"}, bad, 0);
   endtask

   // One transfer: model, push expectations, optionally poke a stray start
   // while busy, wait for completion, then check the write count and memory.
   task automatic run_xfer(input logic m, input logic [SIZE-1:0] s,
                           input logic [SIZE-1:0] d, input logic [SIZE-1:0] n,
                           input logic [31:0] f, input int poke, input string tag);
      int              e0;
      int              w0;
      int              t;
      int              lim;
      wexp_t           e;
      logic [SIZE-1:0] a;
      logic [SIZE-1:0] b;
      @(negedge clk);
      start = 1'b1; mode = m; src = s; dst = d; len = n; fill = f;
      w0 = wr_seen;
      @(posedge clk); #1;
      e0 = cyc;
      start = 1'b0;
      // everything but start is a don't-care once accepted
      src  = SIZE'($urandom_range(0, DEPTH - 1));
      dst  = SIZE'($urandom_range(0, DEPTH - 1));
      len  = SIZE'($urandom_range(0, 20));
      fill = $urandom;
      mode = ~m;
      $display("xfer %s: mode=%0d src=%0d dst=%0d len=%0d fill=0x%0h",
               tag, m, s, d, n, f);
      for (int k = 0; k < int'(n); k++) begin
         a = d + SIZE'(k);
         b = s + SIZE'(k);
         e.addr = a;
         e.data = m ? f : ref_mem[b];
         e.cyc  = e0 + (m ? k : 3 * k + 2);
         ref_mem[a] = e.data;
         wr_q.push_back(e);
      end
      done_q.push_back(e0 + ((n == '0) ? 0 : (m ? int'(n) : 3 * int'(n))));
      chk({tag, "_busy_after_start"}, 32'(busy), 32'(n != '0));
      if (poke > 0) begin
         repeat (poke) @(negedge clk);
         start = 1'b1; mode = 1'b1; len = SIZE'(3);
         @(negedge clk);
         start = 1'b0;
      end
      lim = 3 * int'(n) + 8;
      t = 0;
      while (done_q.size() != 0 && t < lim) begin
         @(posedge clk);
         t++;
      end
      if (done_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s_done_timeout: no done within %0d cycles", tag, lim);
         done_q.delete();
         wr_q.delete();
      end
      chk({tag, "_pending_writes"}, wr_q.size(), 0);
      chk({tag, "_write_count"}, wr_seen - w0, 32'(n));
      chk_mem(tag);
   endtask

   initial begin
      int              e0;
      int              d0;
      wexp_t           e;
      logic            rm;
      logic [SIZE-1:0] rs;
      logic [SIZE-1:0] rd;
      logic [SIZE-1:0] rn;

      for (int j = 0; j < DEPTH; j++) seed_mem[j] = $urandom;
      seed_mem[100]   = 32'd6;
      seed_mem[101]   = 32'd0;
      seed_mem[102]   = 32'hdeadbeef;
      seed_mem[16382] = 32'haaaa_0001;
      seed_mem[16383] = 32'hbbbb_0002;
      seed_mem[0]     = 32'hcccc_0003;
      for (int j = 0; j < DEPTH; j++) ref_mem[j] = seed_mem[j];

      preload = 1'b1;
      repeat (3) @(posedge clk);
      #1 preload = 1'b0;
      @(negedge clk);
      chk("reset_busy",  32'(busy),  32'd0);
      chk("reset_done",  32'(done),  32'd0);
      chk("reset_wren",  32'(wr_en), 32'd0);
      chk("reset_addr",  32'(addr),  32'd0);
      chk("reset_wdata", wdata,      32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Directed copy
      run_xfer(1'b0, SIZE'(100), SIZE'(200), SIZE'(3), 32'h0, 0, "copy3");
      chk("copy3_m200", mem[200], 32'd6);
      chk("copy3_m201", mem[201], 32'd0);
      chk("copy3_m202", mem[202], 32'hdeadbeef);
      chk("copy3_src102", mem[102], 32'hdeadbeef);

      // Directed fill
      run_xfer(1'b1, SIZE'(0), SIZE'(50), SIZE'(4), 32'h3e8, 0, "fill4");
      for (int j = 50; j < 54; j++) chk("fill4_word", mem[j], 32'd1000);
      chk("fill4_m49", mem[49], seed_mem[49]);
      chk("fill4_m54", mem[54], seed_mem[54]);

      // Wrapping, overlapping copy
      run_xfer(1'b0, SIZE'(16382), SIZE'(16383), SIZE'(3), 32'h0, 0, "wrap");
      chk("wrap_m16383", mem[16383], 32'haaaa_0001);
      chk("wrap_m0",     mem[0],     32'haaaa_0001);
      chk("wrap_m1",     mem[1],     32'haaaa_0001);

      // Zero length, then a fill with a stray start while busy
      run_xfer(1'b0, SIZE'(7), SIZE'(9), SIZE'(0), 32'h0, 0, "len0");
      run_xfer(1'b1, SIZE'(0), SIZE'(600), SIZE'(5), 32'h1234_5678, 2, "ignored_start");

      // Reset in the middle of the second word's write of a len=4 copy
      @(negedge clk);
      start = 1'b1; mode = 1'b0; src = SIZE'(300); dst = SIZE'(400); len = SIZE'(4);
      @(posedge clk); #1;
      e0 = cyc;
      start = 1'b0;
      $display("xfer rst_abort: mode=0 src=300 dst=400 len=4");
      e.addr = SIZE'(400);
      e.data = ref_mem[300];
      e.cyc  = e0 + 2;
      ref_mem[400] = e.data;
      wr_q.push_back(e);
      repeat (5) @(posedge clk);
      #2;
      chk("rst_wr_before", 32'(wr_en), 32'd1);
      d0 = dn_seen;
      rst_n = 1'b0;
      #1;
      chk("rst_wren",  32'(wr_en), 32'd0);
      chk("rst_busy",  32'(busy),  32'd0);
      chk("rst_done",  32'(done),  32'd0);
      chk("rst_addr",  32'(addr),  32'd0);
      chk("rst_wdata", wdata,      32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(posedge clk);
      chk("rst_no_done", dn_seen - d0, 0);
      chk("rst_pending_writes", wr_q.size(), 0);
      chk_mem("rst_abort");
      run_xfer(1'b1, SIZE'(0), SIZE'(700), SIZE'(2), 32'hface_0ff0, 0, "after_rst");

      // Randomized transfers, including overlaps and wraps
      for (int t = 0; t < 24; t++) begin
         rm = 1'($urandom_range(0, 1));
         rs = SIZE'($urandom_range(0, DEPTH - 1));
         rn = SIZE'($urandom_range(0, 10));
         if ($urandom_range(0, 2) == 0) rd = rs + SIZE'($urandom_range(1, 4));
         else                           rd = SIZE'($urandom_range(0, DEPTH - 1));
         run_xfer(rm, rs, rd, rn, $urandom, (rn > 3) ? 1 : 0, "rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_copy_dma.md
# mem_copy_dma

Block-copy and fill engine that masters the single-port word RAM (`blram`, one-cycle registered read) on the same bus the CPU uses: `wrEn`, `addr_toRAM`, `data_toRAM`, `data_fromRAM`. It is the initiator side of that RAM protocol. A `start` pulse launches either:

- a copy of `len` words from `src_addr` to `dst_addr`, or
- a fill of `len` words at `dst_addr` with a constant.

It reports progress with `busy` and a one-cycle `done`. The top level muxes its RAM outputs against the CPU's on `busy`; bus arbitration is outside this block.

## Interface
- SIZE, 14, RAM address width in words; the RAM holds 2**SIZE words.
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  launch request; sampled only in IDLE.
- mode  in  1  0 = copy, 1 = fill.
- src_addr  in  SIZE  first source word (copy only).
- dst_addr  in  SIZE  first destination word.
- len  in  SIZE  word count; 0 is legal.
- fill_data  in  32  fill constant (fill only).
- busy  out  1  high from the cycle after an accepted start through the final write cycle.
- done  out  1  one-cycle pulse on completion.
- wrEn  out  1  RAM write enable.
- addr_toRAM  out  SIZE  RAM address.
- data_toRAM  out  32  RAM write data.
- data_fromRAM  in  32  RAM read data; valid in the cycle after the address was presented.

## Operation
- All outputs are registered.
- Reset values: busy=0, done=0, wrEn=0, addr_toRAM=0, data_toRAM=0. The FSM resets to IDLE.
- States: IDLE, RD, WT, WR, FILL, FIN.
- IDLE:
  - Outputs: wrEn=0, addr_toRAM=0.
  - start=1 latches src, dst, len, mode, fill_data, and clears the word index i=0.
  - If len=0: go to FIN.
  - If mode=0: go to RD.
  - If mode=1: go to FILL.
- RD: addr_toRAM=src+i, wrEn=0. Go to WT.
- WT:
  - Drives no new address and wrEn=0.
  - data_fromRAM now holds mem[src+i]; capture it into an internal word register at the end of the cycle.
  - Go to WR.
- WR:
  - addr_toRAM=dst+i, data_toRAM=captured word, wrEn=1.
  - i=i+1.
  - If i==len: go to FIN; otherwise go to RD.
- FILL:
  - addr_toRAM=dst+i, data_toRAM=fill_data, wrEn=1.
  - i=i+1.
  - If i==len: go to FIN; otherwise stay in FILL.
- FIN: done=1, busy=0, wrEn=0. Go to IDLE.
- Address arithmetic is modulo 2**SIZE; src+i and dst+i wrap silently past 2**SIZE-1.
- The index counter is SIZE bits. len=2**SIZE is not representable; the maximum transfer is 2**SIZE-1 words.
- Copy order is ascending, with each read issued after the previous write has committed. When dst lies inside (src, src+len), source words are overwritten before they are read; the result is exactly what this ascending order produces.
- start while busy or in FIN is ignored; no queuing.
- Inputs other than start are don't-care after acceptance.
- Asserting rst mid-operation aborts at once: wrEn drops asynchronously and no done is produced. Words already written stay written.

## Timing
- Let E0 be the posedge at which start is accepted.
- busy rises after E0.
- Copy, per word:
  - RD occupies cycle 3k+1, and the RAM samples the address at the next edge.
  - WT occupies cycle 3k+2.
  - WR occupies cycle 3k+3, and the RAM commits at its closing edge.
- Copy totals: 3·len busy cycles; done is high in cycle 3·len+1 after E0.
- Fill: len busy cycles with one write per cycle; done is high in cycle len+1.
- len=0: busy stays 0; done is high in cycle 1 after E0.
- A new start is accepted at the earliest at the edge that ends FIN, i.e. the cycle after done.

## Test plan
- Copy: mem[100]=6, mem[101]=0, mem[102]=32'hdeadbeef; start mode=0, src=100, dst=200, len=3.
  - mem[200..202]=6, 0, deadbeef.
  - Exactly 3 wrEn pulses.
  - done 10 cycles after E0.
  - Source words unchanged.
- Fill: start mode=1, dst=50, len=4, fill_data=32'h3e8.
  - mem[50..53]=1000.
  - wrEn high for 4 consecutive cycles.
  - done in cycle 5.
  - mem[49] and mem[54] untouched.
- Wrap: copy src=16382, dst=16383, len=3 with mem[16382]=A, mem[16383]=B, mem[0]=C.
  - Addresses wrap.
  - Final state: mem[16383]=A, mem[0]=A, mem[1]=A, matching ascending overlap semantics.
- len=0 plus ignored start:
  - len=0 gives done one cycle after start, with no wrEn.
  - A second start pulsed while busy during a len=5 fill is ignored; exactly 5 writes occur.
- Reset mid-copy: drive rst=0 during the WR of word 2 of a len=4 copy.
  - wrEn=0 immediately; all outputs return to reset values; no done.
  - After release, IDLE accepts a new start normally.
